// File: rtl/msm_pkg.sv
// Shared types for the MSM job path: field width, point/job records, scheduler states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package msm_pkg;

  localparam int FIELD_W = 256;
  // Job records carry the tag in a fixed-width field; the scheduler's TAG_W
  // must not exceed this and is zero-extended into it.
  localparam int TAG_MAX = 32;

  typedef struct packed {
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
  } point_t;

  typedef struct packed {
    logic [FIELD_W-1:0] k;
    point_t             p;
    logic [TAG_MAX-1:0] tag;
  } job_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/msm_job_fifo.sv
// Job FIFO: DEPTH x job_t storage, head shown combinationally, full/empty flags.
// Latency: a push at edge t is visible at the head from t+1; a pop retires the head at the edge.
// Backpressure: a push into a full FIFO is dropped even with a same-cycle pop (caller gates with !full).
// Ports: clk, rst_n (async active-low), push/push_dat, pop, head, full, empty.
module msm_job_fifo
  import msm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  job_t push_dat,
  input  logic pop,
  output job_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset: it is only read while count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/point_mul_scheduler.sv
// Job front-end for point_mul: queues (k, P, tag), launches each with a one-cycle Mul_Reset, returns R + tag.
// Latency: launch 1 cycle after the job is at the head; result valid the cycle after Done (k==0: 1 cycle after head).
// Backpressure: In_ready = !full; a new job starts only once the single-entry output register has drained.
// Ports: job in (In_*), multiplier side (Mul_*), result out (Out_*), status (Busy, sticky Timeout).
module point_mul_scheduler
  import msm_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 8,
  parameter int MAX_CYCLES = 2**20
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 In_valid,
  output logic                 In_ready,
  input  logic [FIELD_W-1:0]   In_k,
  input  logic [FIELD_W-1:0]   In_Px,
  input  logic [FIELD_W-1:0]   In_Py,
  input  logic [TAG_W-1:0]     In_tag,
  output logic                 Mul_Reset,
  output logic [2*FIELD_W-1:0] Mul_P,
  output logic [FIELD_W-1:0]   Mul_k,
  input  logic                 Mul_Done,
  input  logic [2*FIELD_W-1:0] Mul_R,
  output logic                 Out_valid,
  input  logic                 Out_ready,
  output logic [FIELD_W-1:0]   Out_Rx,
  output logic [FIELD_W-1:0]   Out_Ry,
  output logic [TAG_W-1:0]     Out_tag,
  output logic                 Out_zero,
  output logic                 Out_err,
  output logic                 Busy,
  output logic                 Timeout
);

  localparam int CW = $clog2(MAX_CYCLES) + 1;

  state_t        state;
  logic          alive;
  logic [CW-1:0] run_cnt;
  job_t          push_job;
  job_t          head;
  logic          full;
  logic          empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          first_run;
  logic          done_ok;
  logic          wd_hit;
  logic          unused_tag_bits;

  assign push_job = '{k: In_k, p: '{x: In_Px, y: In_Py}, tag: TAG_MAX'(In_tag)};

  // alive keeps In_ready low until the first clock after reset release.
  assign In_ready  = alive && !full;
  assign fifo_push = In_valid && In_ready;

  // run_cnt counts completed RUN cycles; zero means this is the first RUN
  // cycle, where a Done left over from the previous job must be ignored.
  assign first_run = (run_cnt == '0);
  assign done_ok   = Mul_Done && !first_run;
  assign wd_hit    = (run_cnt == CW'(MAX_CYCLES - 1));

  // The head leaves the FIFO only when its result is written to the output register.
  assign fifo_pop = ((state == IDLE) && !empty && !Out_valid && (head.k == '0)) ||
                    ((state == RUN) && (done_ok || wd_hit));

  assign Busy = (state != IDLE) || !empty;

  assign unused_tag_bits = ^head.tag;

  msm_job_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .push     (fifo_push),
    .push_dat (push_job),
    .pop      (fifo_pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      alive     <= 1'b0;
      run_cnt   <= '0;
      Mul_Reset <= 1'b1;   // keep the multiplier parked while we are in reset
      Mul_P     <= '0;
      Mul_k     <= '0;
      Out_valid <= 1'b0;
      Out_Rx    <= '0;
      Out_Ry    <= '0;
      Out_tag   <= '0;
      Out_zero  <= 1'b0;
      Out_err   <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      alive     <= 1'b1;
      Mul_Reset <= 1'b0;
      if (Out_valid && Out_ready) Out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!empty && !Out_valid) begin
            if (head.k == '0) begin
              // k == 0 gives the point at infinity without using the multiplier.
              Out_valid <= 1'b1;
              Out_Rx    <= '0;
              Out_Ry    <= '0;
              Out_tag   <= head.tag[TAG_W-1:0];
              Out_zero  <= 1'b1;
              Out_err   <= 1'b0;
            end else begin
              // Mul_Reset is registered, so it is high exactly during LAUNCH.
              Mul_Reset <= 1'b1;
              Mul_P     <= head.p;
              Mul_k     <= head.k;
              state     <= LAUNCH;
            end
          end
        end

        LAUNCH: begin
          run_cnt <= '0;
          state   <= RUN;
        end

        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          // A genuine Done on the last allowed cycle wins over the watchdog.
          if (done_ok) begin
            Out_valid <= 1'b1;
            Out_Rx    <= Mul_R[2*FIELD_W-1:FIELD_W];
            Out_Ry    <= Mul_R[FIELD_W-1:0];
            Out_tag   <= head.tag[TAG_W-1:0];
            Out_zero  <= 1'b0;
            Out_err   <= 1'b0;
            state     <= IDLE;
          end else if (wd_hit) begin
            Timeout   <= 1'b1;
            Out_valid <= 1'b1;
            Out_Rx    <= '0;
            Out_Ry    <= '0;
            Out_tag   <= head.tag[TAG_W-1:0];
            Out_zero  <= 1'b0;
            Out_err   <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
